// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller.
package cpu_types_pkg;

  localparam int REGW_DEF = 5;

  // Register-select value at the default register-file width.
  typedef logic [REGW_DEF-1:0] regbits_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  // Which pipeline-control pattern is active in the current cycle.
  typedef enum logic [2:0] {
    DEC_IDLE    = 3'd0,
    DEC_DSTALL  = 3'd1,
    DEC_HALT    = 3'd2,
    DEC_BRANCH  = 3'd3,
    DEC_LOADUSE = 3'd4,
    DEC_IMISS   = 3'd5,
    DEC_RUN     = 3'd6
  } hazard_dec_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: counts up by one on each cycle with inc set and
// holds at all-ones once full.
module hazard_perf_cnt #(
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // Next count: step when requested and not already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= {CNTW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/bubble control for data-memory
// stalls, halt draining, taken branches, load-use hazards and fetch misses.
// Optional build macro HAZARD_PERF_EN adds saturating performance counters;
// without it the counter ports read zero.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int EX_STAGE = 2,
  parameter int ME_STAGE = 3,
  parameter int REGW     = 5,
  parameter int CNTW     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              ldst,
  input  logic              halt_me,
  input  logic              branch_taken,
  input  logic              load_ex,
  input  logic [REGW-1:0]   wsel_ex,
  input  logic [REGW-1:0]   rs_de,
  input  logic [REGW-1:0]   rt_de,
  input  logic [1:0]        use_de,
  output logic [NSTAGE-1:0] en,
  output logic [NSTAGE-1:0] flush,
  output logic              halt,
  output logic [CNTW-1:0]   stall_cycles,
  output logic [CNTW-1:0]   flush_events,
  output logic [CNTW-1:0]   lu_events
);

  // Stages behind the ME stage that must still retire after a halt.
  localparam int DRAIN_LEN = NSTAGE - 1 - ME_STAGE;
  localparam int DCW       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN + 1) : 1;

  function automatic logic [NSTAGE-1:0] stage_mask(input int lo, input int hi);
    logic [NSTAGE-1:0] m;
    m = {NSTAGE{1'b0}};
    for (int k = 0; k < NSTAGE; k++) begin
      if ((k >= lo) && (k <= hi)) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

  localparam logic [NSTAGE-1:0] ALL_EN      = {NSTAGE{1'b1}};
  localparam logic [NSTAGE-1:0] NONE        = {NSTAGE{1'b0}};
  localparam logic [NSTAGE-1:0] HALT_EN     = stage_mask(ME_STAGE + 1, NSTAGE - 1);
  localparam logic [NSTAGE-1:0] HALT_FLUSH  = stage_mask(1, ME_STAGE);
  localparam logic [NSTAGE-1:0] BR_FLUSH    = stage_mask(1, EX_STAGE);
  localparam logic [NSTAGE-1:0] LU_EN       = stage_mask(EX_STAGE, NSTAGE - 1);
  localparam logic [NSTAGE-1:0] LU_FLUSH    = stage_mask(EX_STAGE, EX_STAGE);
  localparam logic [NSTAGE-1:0] IMISS_EN    = stage_mask(1, NSTAGE - 1);
  localparam logic [NSTAGE-1:0] IMISS_FLUSH = stage_mask(1, 1);

  hazard_state_t  state_q;
  logic [DCW-1:0] drain_q;
  logic           halt_q;
  hazard_dec_t    dec_s;
  logic           dstall_s;
  logic           lu_s;

  // Raw hazard conditions; register 0 is never a real dependency.
  always_comb begin
    dstall_s = ldst & ~dhit;
    lu_s     = load_ex & (wsel_ex != {REGW{1'b0}}) &
               ((use_de[0] & (rs_de == wsel_ex)) | (use_de[1] & (rt_de == wsel_ex)));
  end

  // Priority selection of this cycle's control pattern.
  always_comb begin
    dec_s = DEC_IDLE;
    case (state_q)
      RUN: begin
        if (dstall_s) begin
          dec_s = DEC_DSTALL;
        end else if (halt_me) begin
          dec_s = DEC_HALT;
        end else if (branch_taken) begin
          dec_s = DEC_BRANCH;
        end else if (lu_s) begin
          dec_s = DEC_LOADUSE;
        end else if (!ihit) begin
          dec_s = DEC_IMISS;
        end else begin
          dec_s = DEC_RUN;
        end
      end
      DRAIN:   dec_s = DEC_HALT;
      HALTED:  dec_s = DEC_IDLE;
      default: dec_s = DEC_IDLE;
    endcase
  end

  // Zero-latency enable/bubble vectors for the chosen pattern.
  always_comb begin
    en    = NONE;
    flush = NONE;
    case (dec_s)
      DEC_DSTALL: begin
        en    = NONE;
        flush = NONE;
      end
      DEC_HALT: begin
        en    = HALT_EN;
        flush = HALT_FLUSH;
      end
      DEC_BRANCH: begin
        en    = ALL_EN;
        flush = BR_FLUSH;
      end
      DEC_LOADUSE: begin
        en    = LU_EN;
        flush = LU_FLUSH;
      end
      DEC_IMISS: begin
        en    = IMISS_EN;
        flush = IMISS_FLUSH;
      end
      DEC_RUN: begin
        en    = ALL_EN;
        flush = NONE;
      end
      default: begin
        en    = NONE;
        flush = NONE;
      end
    endcase
  end

  // Controller FSM: drain the back end after a halt, then stay halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      drain_q <= {DCW{1'b0}};
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dec_s == DEC_HALT) begin
            if (DRAIN_LEN == 0) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              drain_q <= DCW'(DRAIN_LEN);
            end
          end else begin
            state_q <= RUN;
          end
        end
        DRAIN: begin
          if (drain_q <= DCW'(1)) begin
            state_q <= HALTED;
            drain_q <= {DCW{1'b0}};
            halt_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        HALTED: begin
          state_q <= HALTED;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          drain_q <= {DCW{1'b0}};
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign halt = halt_q;

`ifdef HAZARD_PERF_EN
  logic stall_inc_s;
  logic flush_inc_s;
  logic lu_inc_s;

  assign stall_inc_s = (state_q == RUN) & ~en[0];
  assign flush_inc_s = (dec_s == DEC_BRANCH);
  assign lu_inc_s    = (dec_s == DEC_LOADUSE);

  hazard_perf_cnt #(.CNTW(CNTW)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc_s),
    .cnt  (stall_cycles)
  );

  hazard_perf_cnt #(.CNTW(CNTW)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc_s),
    .cnt  (flush_events)
  );

  hazard_perf_cnt #(.CNTW(CNTW)) u_lu_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (lu_inc_s),
    .cnt  (lu_events)
  );
`else
  assign stall_cycles = {CNTW{1'b0}};
  assign flush_events = {CNTW{1'b0}};
  assign lu_events    = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl at default stage parameters, 4-bit counters.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int CNTW = 4;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b1, dhit = 1'b1, ldst = 1'b0, halt_me = 1'b0;
  logic       branch_taken = 1'b0, load_ex = 1'b0;
  regbits_t   wsel_ex = '0, rs_de = '0, rt_de = '0;
  logic [1:0] use_de = 2'b00;
  logic [4:0] en, flush;
  logic       halt;
  logic [CNTW-1:0] stall_cycles, flush_events, lu_events;

  hazard_ctrl #(.NSTAGE(5), .EX_STAGE(2), .ME_STAGE(3), .REGW(5), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ldst(ldst), .halt_me(halt_me),
    .branch_taken(branch_taken), .load_ex(load_ex), .wsel_ex(wsel_ex), .rs_de(rs_de),
    .rt_de(rt_de), .use_de(use_de), .en(en), .flush(flush), .halt(halt),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .lu_events(lu_events)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] en;
    logic [4:0] flush;
    logic       halt;
    logic [3:0] st;
    logic [3:0] fe;
    logic [3:0] le;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: 0 RUN, 1 DRAIN, 2 HALTED.
  int   m_state, m_drain, m_st, m_fe, m_le;
  logic m_halt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_drain = 0; m_halt = 1'b0;
    m_st = 0; m_fe = 0; m_le = 0;
  endtask

  // One clock cycle: drive, predict, compare, advance the model.
  task automatic step(input bit ih, input bit dh, input bit ld, input bit hm, input bit br,
                      input bit le, input regbits_t ws, input regbits_t rs, input regbits_t rt,
                      input logic [1:0] us, input bit pulse_rst);
    exp_t e, got;
    int   kind;
    bit   lu;
    @(negedge CLK);
    ihit = ih; dhit = dh; ldst = ld; halt_me = hm; branch_taken = br;
    load_ex = le; wsel_ex = ws; rs_de = rs; rt_de = rt; use_de = us;
    if (pulse_rst) begin
      #1;
      nRST = 1'b0;
      m_reset();
    end
    lu = le && (ws != 5'd0) && ((us[0] && rs == ws) || (us[1] && rt == ws));
    if (m_state == 2)      kind = 6;
    else if (m_state == 1) kind = 1;
    else if (ld && !dh)    kind = 0;
    else if (hm)           kind = 1;
    else if (br)           kind = 2;
    else if (lu)           kind = 3;
    else if (!ih)          kind = 4;
    else                   kind = 5;
    case (kind)
      0:       begin e.en = 5'b00000; e.flush = 5'b00000; end
      1:       begin e.en = 5'b10000; e.flush = 5'b01110; end
      2:       begin e.en = 5'b11111; e.flush = 5'b00110; end
      3:       begin e.en = 5'b11100; e.flush = 5'b00100; end
      4:       begin e.en = 5'b11110; e.flush = 5'b00010; end
      5:       begin e.en = 5'b11111; e.flush = 5'b00000; end
      default: begin e.en = 5'b00000; e.flush = 5'b00000; end
    endcase
    e.halt = m_halt;
`ifdef HAZARD_PERF_EN
    e.st = 4'(m_st); e.fe = 4'(m_fe); e.le = 4'(m_le);
`else
    e.st = 4'd0; e.fe = 4'd0; e.le = 4'd0;
`endif
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check_eq("en", en, got.en);
    check_eq("flush", flush, got.flush);
    check_eq("halt", halt, got.halt);
    check_eq("stall_cycles", stall_cycles, got.st);
    check_eq("flush_events", flush_events, got.fe);
    check_eq("lu_events", lu_events, got.le);
    if (pulse_rst) nRST = 1'b1;
    if (nRST) begin
      if (m_state == 0) begin
        if (e.en[0] == 1'b0 && m_st < 15) m_st++;
        if (kind == 2 && m_fe < 15) m_fe++;
        if (kind == 3 && m_le < 15) m_le++;
        if (kind == 1) begin
          m_state = 1;
          m_drain = 1;
        end
      end else if (m_state == 1) begin
        m_drain--;
        if (m_drain == 0) begin
          m_state = 2;
          m_halt = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input bit pulse_rst);
    step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, pulse_rst);
  endtask

  task automatic rand_step(input bit allow_halt, input bit pulse_rst);
    step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
         allow_halt ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 3) == 0),
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pulse_rst);
  endtask

  initial begin
    m_reset();
    // Reset state, then release.
    idle(0);
    idle(0);
    nRST = 1'b1;
    idle(0);
    // Load-use on rs; same with wsel_ex = 0 (no hazard).
    step(1, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 2'b01, 0);
    step(1, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 2'b01, 0);
    // Load-use on rt; rs match without rs use is not a hazard.
    step(1, 1, 0, 0, 0, 1, 5'd7, 5'd0, 5'd7, 2'b10, 0);
    step(1, 1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 2'b10, 0);
    // Fetch miss.
    step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    // Branch overrides load-use and fetch miss.
    step(0, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 2'b01, 0);
    // Data stall overrides branch, then completes.
    step(1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    step(1, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    // Data stall also blocks a halt.
    step(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    idle(0);
    // Counter saturation.
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 2'b01, 0);
    // Mixed traffic without halts.
    for (int i = 0; i < 40; i++) rand_step(1'b0, 1'b0);
    // Halt, then reset while draining.
    step(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    step(0, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 2'b01, 1);
    for (int i = 0; i < 3; i++) idle(0);
    step(1, 1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 2'b01, 0);
    // Full halt with inputs ignored, then reset while halted.
    step(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    for (int i = 0; i < 6; i++) rand_step(1'b1, 1'b0);
    step(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00, 1);
    idle(0);
    step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 NSTAGE, default 5: pipeline stage count (>=4); en/flush bit k controls the register feeding stage k, bit 0 = PC.
REQ-002 EX_STAGE, default 2: stage index that resolves branches and load-use hazards (1 < EX_STAGE < ME_STAGE).
REQ-003 ME_STAGE, default 3: data-memory stage index (ME_STAGE < NSTAGE).
REQ-004 REGW, default 5: register-select width.
REQ-005 CNTW, default 32: performance-counter width.
REQ-006 CLK  input  1  clock, rising edge; the only clock.
REQ-007 nRST  input  1  reset, asynchronous, active-low.
REQ-008 ihit  input  1  instruction fetch complete this cycle.
REQ-009 dhit  input  1  data access complete this cycle.
REQ-010 ldst  input  1  ME stage holds a data read or write request.
REQ-011 halt_me  input  1  halt instruction in ME stage.
REQ-012 branch_taken  input  1  EX stage redirects the PC.
REQ-013 load_ex  input  1  EX stage holds a load.
REQ-014 wsel_ex  input  REGW  destination register of the EX-stage load.
REQ-015 rs_de  input  REGW  rs of the decode-stage instruction.
REQ-016 rt_de  input  REGW  rt of the decode-stage instruction.
REQ-017 use_de  input  2  [0] decode reads rs, [1] decode reads rt.
REQ-018 en  output  NSTAGE  per-stage register enable.
REQ-019 flush  output  NSTAGE  per-stage bubble insert; flush[k]=1 loads a bubble into register k regardless of en[k].
REQ-020 halt  output  1  core halted, sticky.
REQ-021 stall_cycles, flush_events, lu_events  output  CNTW each  performance counters.

Function
REQ-022 FSM states RUN, DRAIN, HALTED; en/flush are combinational from the state and same-cycle inputs (zero latency).
REQ-023 RUN priority 1, dstall = ldst & ~dhit: en = 0, flush = 0.
REQ-024 RUN priority 2, halt_me: en[k]=1 for k>ME_STAGE, else 0; flush[1..ME_STAGE]=1; next state DRAIN for D = NSTAGE-1-ME_STAGE cycles, or HALTED directly when D=0.
REQ-025 RUN priority 3, branch_taken: en all 1, flush[1..EX_STAGE]=1; overrides load-use and ~ihit.
REQ-026 RUN priority 4, lu = load_ex & (wsel_ex!=0) & ((use_de[0]&rs_de==wsel_ex) | (use_de[1]&rt_de==wsel_ex)): en[0..EX_STAGE-1]=0, flush[EX_STAGE]=1, remaining en=1; overrides ~ihit.
REQ-027 RUN priority 5, ~ihit: en[0]=0, flush[1]=1, remaining en=1.
REQ-028 RUN otherwise: en all 1, flush all 0.
REQ-029 DRAIN: en and flush as in REQ-024; all other inputs are ignored; a down-counter reaching 0 moves the FSM to HALTED.
REQ-030 HALTED: en=0, flush=0, halt=1 until reset; halt is registered and asserts D+1 cycles after the halt_me cycle.
REQ-031 Counters increment only in RUN: stall_cycles when en[0]=0, flush_events when REQ-025 applies, lu_events when REQ-026 applies; all saturate at all-ones.

Reset
REQ-032 On nRST low, immediately (including mid-DRAIN): state=RUN, drain counter=0, halt=0, all counters=0; en/flush then follow the RUN rules.

Configuration
REQ-033 With HAZARD_PERF_EN defined, the counters are implemented as in REQ-031; without it, counter logic is omitted and all three ports are tied to 0.

Structure
REQ-034 The hazard_state_t enum and regbits_t belong in cpu_types_pkg; one sub-module, hazard_perf_cnt (CNTW saturating counter with inc input), is instantiated three times.

Verification (default parameters)
REQ-035 load_ex=1, wsel_ex=5, rs_de=5, use_de=01, ihit=1 -> en=11100, flush=00100, lu_events+1; repeat with wsel_ex=0 -> en=11111, flush=00000.
REQ-036 branch_taken=1 with an active lu and ihit=0 -> en=11111, flush=00110, flush_events+1, lu_events unchanged.
REQ-037 ldst=1, dhit=0, branch_taken=1 -> en=00000, flush=00000, stall_cycles+1; dhit=1 next cycle -> en=11111, flush=00110.
REQ-038 halt_me=1 at cycle t -> en=10000, flush=01110 at t and t+1 (DRAIN); halt=1 and en=00000 from t+2 onward, ignoring all inputs.
REQ-039 nRST pulsed low at t+1 of REQ-038 -> halt=0 and counters=0 asynchronously; RUN behaviour resumes; with HAZARD_PERF_EN undefined all counters read 0 throughout.
